// File: rtl/rv32e_data_mem_if.sv
// Data-memory bus between the rv32e CPU (master) and the data memory /
// I/O responder (slave). Word-addressed loads are combinational, and stores
// are marked by a level write strobe.
interface rv32e_data_mem_if;
    logic [31:0] mem_addr_bus;
    logic [31:0] mem_write_data_bus;
    logic        mem_write_signal;
    logic [31:0] mem_read_data_bus;

    modport master (
        output mem_addr_bus,
        output mem_write_data_bus,
        output mem_write_signal,
        input  mem_read_data_bus
    );

    modport slave (
        input  mem_addr_bus,
        input  mem_write_data_bus,
        input  mem_write_signal,
        output mem_read_data_bus
    );
endinterface

// File: rtl/rv32e_data_mem.sv
// Responder side of the rv32e data-memory bus.
// Word RAM plus a four-register I/O bank (GPIO, CYCLE, CMP, STATUS).
// Reads are a purely combinational decode of the current address.
// A store commits once per rising edge of the write strobe.
module rv32e_data_mem #(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] IO_BASE   = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    reset,
    rv32e_data_mem_if.slave         bus,
    output logic [31:0]             gpio_out,
    output logic                    timer_match
);
    localparam int IDX_W = $clog2(RAM_WORDS);

    // I/O register offsets, as word selects within the 16-byte bank
    localparam int IO_GPIO   = 0;
    localparam int IO_CYCLE  = 1;
    localparam int IO_CMP    = 2;
    localparam int IO_STATUS = 3;

    // Storage
    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_gpio;
    logic [31:0] r_cycle;
    logic [31:0] r_cmp;
    logic        r_flag;
    logic        r_wr_q;

    // Decode
    logic [IDX_W-1:0] w_ram_idx;
    logic             w_is_ram;
    logic             w_is_io;
    logic [1:0]       w_io_sel;
    logic             w_commit;
    logic             w_ram_wr;
    logic [3:0]       w_io_hit;
    logic [3:0]       w_io_wr;
    logic [31:0]      w_io_rd [4];
    logic             w_match;
    logic             w_clear;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Byte-lane bits are don't-care: every access is a full word.
    assign w_unused  = ^bus.mem_addr_bus[1:0];

    assign w_ram_idx = bus.mem_addr_bus[IDX_W+1:2];
    // Inside RAM when no word-index bit above the RAM index is set.
    assign w_is_ram  = (bus.mem_addr_bus[31:IDX_W+2] == '0);
    assign w_is_io   = (bus.mem_addr_bus[31:4] == IO_BASE[31:4]);
    assign w_io_sel  = bus.mem_addr_bus[3:2];

    // A store lands only on the first cycle of the strobe, so a CPU that
    // holds the strobe for several cycles still writes exactly once.
    assign w_commit  = bus.mem_write_signal & ~r_wr_q;
    assign w_ram_wr  = w_commit & w_is_ram;

    // Per-register select and write enables for the I/O bank
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_io_dec
            assign w_io_hit[gi] = w_is_io && (w_io_sel == 2'(gi));
            assign w_io_wr[gi]  = w_commit & w_io_hit[gi];
        end
    endgenerate

    assign w_io_rd[IO_GPIO]   = r_gpio;
    assign w_io_rd[IO_CYCLE]  = r_cycle;
    assign w_io_rd[IO_CMP]    = r_cmp;
    assign w_io_rd[IO_STATUS] = {31'b0, r_flag};

    // Compare uses the counter value before this edge's update and the
    // CMP value before any write landing on this same edge.
    assign w_match = (r_cycle == r_cmp);
    assign w_clear = w_io_wr[IO_STATUS] & bus.mem_write_data_bus[0];

    // Strobe history for store edge detection; cleared so that a strobe
    // still high when reset drops is treated as a fresh store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_q <= 1'b0;
        end else begin
            r_wr_q <= bus.mem_write_signal;
        end
    end

    // RAM contents are never reset; software initialises what it reads.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_ram_idx] <= bus.mem_write_data_bus;
        end
    end

    // GPIO output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio <= 32'h0;
        end else if (w_io_wr[IO_GPIO]) begin
            r_gpio <= bus.mem_write_data_bus;
        end
    end

    // Free-running cycle counter; a store replaces that edge's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'h0;
        end else if (w_io_wr[IO_CYCLE]) begin
            r_cycle <= bus.mem_write_data_bus;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Compare register; resets to all-ones so a match is far away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmp <= 32'hFFFF_FFFF;
        end else if (w_io_wr[IO_CMP]) begin
            r_cmp <= bus.mem_write_data_bus;
        end
    end

    // Sticky match flag; a coincident set beats a software clear so that
    // a match can never be lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= w_match | (r_flag & ~w_clear);
        end
    end

    // Combinational read mux: RAM word, I/O register, or zero for holes.
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_is_io) begin
            w_rdata = w_io_rd[w_io_sel];
        end
    end

    assign bus.mem_read_data_bus = w_rdata;
    assign gpio_out              = r_gpio;
    assign timer_match           = r_flag;

endmodule

// File: tb/tb_rv32e_data_mem.sv
// Directed bench for rv32e_data_mem: RAM store/load, single commit per
// strobe, I/O bank behaviour, counter wrap, compare flag, async reset.
module tb_rv32e_data_mem;
    localparam logic [31:0] A_GPIO   = 32'h0000_1000;
    localparam logic [31:0] A_CYCLE  = 32'h0000_1004;
    localparam logic [31:0] A_CMP    = 32'h0000_1008;
    localparam logic [31:0] A_STATUS = 32'h0000_100C;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_out;
    logic        timer_match;
    int          n_checks;
    int          n_pass;

    rv32e_data_mem_if bus ();

    rv32e_data_mem #(
        .RAM_WORDS (256),
        .IO_BASE   (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .gpio_out    (gpio_out),
        .timer_match (timer_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.mem_addr_bus = addr;
        #1;
        chk(tag, bus.mem_read_data_bus, exp);
    endtask

    // One-cycle strobe, then one idle edge so the next store is a new edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_addr_bus       = addr;
        bus.mem_write_data_bus = data;
        bus.mem_write_signal   = 1'b1;
        tick();
        bus.mem_write_signal   = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus.mem_addr_bus       = 32'h0;
        bus.mem_write_data_bus = 32'h0;
        bus.mem_write_signal   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_match", {31'b0, timer_match}, 32'h0);
        rd("rst_cycle", A_CYCLE, 32'h0);
        rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rst_status", A_STATUS, 32'h0);
        reset = 1'b0;
        tick();

        // 1: single store and load, byte bits ignored
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_0x10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_0x13", 32'h13, 32'hDEAD_BEEF);
        rd("above_ram", 32'h400, 32'h0);

        // 2: strobe held three cycles with changing data -> first value only
        bus.mem_addr_bus       = 32'h20;
        bus.mem_write_data_bus = 32'h1;
        bus.mem_write_signal   = 1'b1;
        tick();
        bus.mem_write_data_bus = 32'h2;
        tick();
        bus.mem_write_data_bus = 32'h3;
        tick();
        bus.mem_write_signal   = 1'b0;
        tick();
        rd("held_strobe", 32'h20, 32'h1);
        rd("ram_keep", 32'h10, 32'hDEAD_BEEF);

        // 3: GPIO store visible right after the commit edge
        bus.mem_addr_bus       = A_GPIO;
        bus.mem_write_data_bus = 32'hA5;
        bus.mem_write_signal   = 1'b1;
        tick();
        chk("gpio_next", gpio_out, 32'hA5);
        bus.mem_write_signal   = 1'b0;
        tick();
        rd("io_hole", 32'h1014, 32'h0);
        chk("gpio_after_hole", gpio_out, 32'hA5);
        rd("gpio_read", A_GPIO, 32'hA5);
        wr(32'h800, 32'hFF);
        rd("unmapped_rd", 32'h800, 32'h0);
        chk("gpio_unmapped_wr", gpio_out, 32'hA5);

        // 4: counter load and wrap; pre-edge FFFF_FFFF matches reset CMP
        bus.mem_addr_bus       = A_CYCLE;
        bus.mem_write_data_bus = 32'hFFFF_FFFE;
        bus.mem_write_signal   = 1'b1;
        tick();
        bus.mem_write_signal   = 1'b0;
        chk("cyc_load", bus.mem_read_data_bus, 32'hFFFF_FFFE);
        tick();
        chk("cyc_max", bus.mem_read_data_bus, 32'hFFFF_FFFF);
        chk("no_match_yet", {31'b0, timer_match}, 32'h0);
        tick();
        chk("cyc_wrap", bus.mem_read_data_bus, 32'h0);
        chk("wrap_match", {31'b0, timer_match}, 32'h1);

        // 6: mid-cycle reset clears state at once and drops a pending store
        wr(A_CMP, 32'h0000_1234);
        bus.mem_addr_bus       = A_GPIO;
        bus.mem_write_data_bus = 32'h77;
        bus.mem_write_signal   = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("async_gpio", gpio_out, 32'h0);
        chk("async_match", {31'b0, timer_match}, 32'h0);
        rd("async_cycle", A_CYCLE, 32'h0);
        rd("async_cmp", A_CMP, 32'hFFFF_FFFF);
        bus.mem_addr_bus       = A_GPIO;
        bus.mem_write_data_bus = 32'h55;
        tick();
        chk("discarded_wr", gpio_out, 32'h0);
        reset = 1'b0;
        tick();
        chk("release_commit", gpio_out, 32'h55);
        bus.mem_write_signal = 1'b0;
        tick();

        // 5: compare match, sticky flag, clear, set-beats-clear
        wr(A_CMP, 32'd50);
        wr(A_CYCLE, 32'd40);
        rd("cyc_41", A_CYCLE, 32'd41);
        for (int i = 0; i < 9; i++) tick();
        chk("cyc_50", bus.mem_read_data_bus, 32'd50);
        chk("match_low_50", {31'b0, timer_match}, 32'h0);
        tick();
        chk("cyc_51", bus.mem_read_data_bus, 32'd51);
        chk("match_at_51", {31'b0, timer_match}, 32'h1);
        tick();
        chk("match_sticky", {31'b0, timer_match}, 32'h1);
        rd("status_rd", A_STATUS, 32'h1);
        wr(A_CYCLE, 32'd49);
        bus.mem_addr_bus       = A_STATUS;
        bus.mem_write_data_bus = 32'h1;
        bus.mem_write_signal   = 1'b1;
        tick();
        bus.mem_write_signal   = 1'b0;
        chk("set_beats_clear", {31'b0, timer_match}, 32'h1);
        tick();
        wr(A_STATUS, 32'h1);
        chk("flag_cleared", {31'b0, timer_match}, 32'h0);
        rd("status_clr_rd", A_STATUS, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
